// File: rtl/ddr_line_sched.sv
// ddr_line_sched: DDR burst sequencer/arbiter for cache line traffic and VGA fetch.
// Optional macro VGA_DEADLINE_EN: a VGA request waiting too long outranks fills.
module ddr_line_sched #(
   parameter int ADDR         = 25,
   parameter int LINE         = 6,
   parameter int VGA_MAX_WAIT = 64
) (
   input  logic                 ddr_clk,
   input  logic                 rst_n,
   input  logic                 ddr_rd,
   input  logic                 ddr_wr,
   input  logic [ADDR-LINE-1:0] hiaddr,
   output logic                 cache_write_data,
   output logic                 cache_read_data,
   input  logic [15:0]          ddr_dout,
   output logic [15:0]          ddr_din,
   input  logic                 vga_req,
   input  logic [ADDR-LINE-1:0] vga_line_addr,
   output logic                 vga_ack,
   output logic                 vga_rdata_valid,
   output logic [15:0]          vga_rdata,
   output logic                 mem_cmd_valid,
   input  logic                 mem_cmd_ready,
   output logic                 mem_cmd_we,
   output logic [ADDR-LINE-1:0] mem_cmd_addr,
   input  logic                 mem_rdata_valid,
   input  logic [15:0]          mem_rdata,
   input  logic                 mem_wdata_req,
   output logic [15:0]          mem_wdata,
   output logic                 busy
);

   typedef enum logic [1:0] {IDLE, CMD, XFER, DONE} state_t;

   state_t          state;
   logic [LINE-2:0] cnt;
   logic            to_vga;
   logic            arm_wr, arm_rd, arm_vga;
   logic            wr_e, rd_e, vga_e;
   logic            g_wr, g_rd, g_vga;
   logic            beat;

   assign wr_e  = ddr_wr & arm_wr;
   assign rd_e  = ddr_rd & arm_rd;
   assign vga_e = vga_req & arm_vga;
   assign beat  = (state == XFER) &&
                  (mem_cmd_we ? mem_wdata_req : mem_rdata_valid);

   assign vga_ack = g_vga;
   assign busy    = (state != IDLE);

`ifdef VGA_DEADLINE_EN
   localparam logic [6:0] MAXW = 7'(VGA_MAX_WAIT);
   logic [6:0] wcnt;
   logic       late;

   assign late = (wcnt >= MAXW);

   // Age an eligible VGA request that keeps losing arbitration.
   always_ff @(posedge ddr_clk or negedge rst_n) begin
      if (!rst_n) begin
         wcnt <= '0;
      end else if (!vga_req || g_vga) begin
         wcnt <= '0;
      end else if (vga_e && wcnt != 7'd127) begin
         wcnt <= wcnt + 7'd1;
      end
   end
`else
   logic unused_wait;
   assign unused_wait = ^VGA_MAX_WAIT;
`endif

   // Pick the winner in IDLE: write-back, then fill, then VGA.
   always_comb begin
      g_wr  = 1'b0;
      g_rd  = 1'b0;
      g_vga = 1'b0;
      if (state == IDLE) begin
         if (wr_e) g_wr = 1'b1;
`ifdef VGA_DEADLINE_EN
         else if (vga_e && late) g_vga = 1'b1;
`endif
         else if (rd_e) g_rd = 1'b1;
         else if (vga_e) g_vga = 1'b1;
      end
   end

   // Drop an arm flag at grant; re-arm once the request is seen low.
   always_ff @(posedge ddr_clk or negedge rst_n) begin
      if (!rst_n) begin
         arm_wr  <= 1'b1;
         arm_rd  <= 1'b1;
         arm_vga <= 1'b1;
      end else begin
         if (!ddr_wr) arm_wr <= 1'b1;
         else if (g_wr) arm_wr <= 1'b0;
         if (!ddr_rd) arm_rd <= 1'b1;
         else if (g_rd) arm_rd <= 1'b0;
         if (!vga_req) arm_vga <= 1'b1;
         else if (g_vga) arm_vga <= 1'b0;
      end
   end

   // Burst sequencer: command handshake, word count, drain cycle.
   always_ff @(posedge ddr_clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         cnt           <= '0;
         to_vga        <= 1'b0;
         mem_cmd_valid <= 1'b0;
         mem_cmd_we    <= 1'b0;
         mem_cmd_addr  <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (g_wr || g_rd || g_vga) begin
                  state         <= CMD;
                  mem_cmd_valid <= 1'b1;
                  mem_cmd_we    <= g_wr;
                  to_vga        <= g_vga;
                  mem_cmd_addr  <= g_vga ? vga_line_addr : hiaddr;
               end
            end
            CMD: begin
               if (mem_cmd_ready) begin
                  mem_cmd_valid <= 1'b0;
                  state         <= XFER;
               end
            end
            XFER: begin
               if (beat) begin
                  cnt <= cnt + 1'b1;
                  if (cnt == '1) state <= DONE;
               end
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Data routing and per-word strobes, one cycle behind the DDR beat.
   always_ff @(posedge ddr_clk or negedge rst_n) begin
      if (!rst_n) begin
         cache_write_data <= 1'b0;
         cache_read_data  <= 1'b0;
         vga_rdata_valid  <= 1'b0;
         ddr_din          <= '0;
         vga_rdata        <= '0;
         mem_wdata        <= '0;
      end else begin
         cache_write_data <= 1'b0;
         cache_read_data  <= 1'b0;
         vga_rdata_valid  <= 1'b0;
         mem_wdata        <= ddr_dout;
         if (beat && !mem_cmd_we) begin
            if (to_vga) begin
               vga_rdata       <= mem_rdata;
               vga_rdata_valid <= 1'b1;
            end else begin
               ddr_din          <= mem_rdata;
               cache_write_data <= 1'b1;
            end
         end
         if (beat && mem_cmd_we) cache_read_data <= 1'b1;
      end
   end

endmodule

// File: tb/tb_ddr_line_sched.sv
// tb_ddr_line_sched: directed vectors and corner sequences for ddr_line_sched.
// Models the cache write-back source and the DDR command/data side.
module tb_ddr_line_sched;

   logic        clk;
   logic        rst_n;
   logic        ddr_rd, ddr_wr, vga_req;
   logic [18:0] hiaddr, vga_line_addr;
   logic        cache_write_data, cache_read_data;
   logic [15:0] ddr_dout, ddr_din;
   logic        vga_ack, vga_rdata_valid;
   logic [15:0] vga_rdata;
   logic        mem_cmd_valid, mem_cmd_ready, mem_cmd_we;
   logic [18:0] mem_cmd_addr;
   logic        mem_rdata_valid;
   logic [15:0] mem_rdata;
   logic        mem_wdata_req;
   logic [15:0] mem_wdata;
   logic        busy;

   ddr_line_sched dut (
      .ddr_clk(clk), .rst_n(rst_n),
      .ddr_rd(ddr_rd), .ddr_wr(ddr_wr), .hiaddr(hiaddr),
      .cache_write_data(cache_write_data),
      .cache_read_data(cache_read_data),
      .ddr_dout(ddr_dout), .ddr_din(ddr_din),
      .vga_req(vga_req), .vga_line_addr(vga_line_addr),
      .vga_ack(vga_ack), .vga_rdata_valid(vga_rdata_valid),
      .vga_rdata(vga_rdata),
      .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready),
      .mem_cmd_we(mem_cmd_we), .mem_cmd_addr(mem_cmd_addr),
      .mem_rdata_valid(mem_rdata_valid), .mem_rdata(mem_rdata),
      .mem_wdata_req(mem_wdata_req), .mem_wdata(mem_wdata),
      .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   int n_cwd = 0, n_crd = 0, n_vrv = 0, n_ack = 0, n_multi = 0;
   int n_wchk = 0, n_wbad = 0;
   logic [15:0] fill_log [1024];
   logic [15:0] vga_log  [1024];
   logic        wd1 = 1'b0, wd2 = 1'b0;
   logic [15:0] wptr = 16'd0;

   assign ddr_dout = 16'hA500 + wptr;

   // Cache model: word pointer advances on each write-back strobe.
   always @(posedge clk) begin
      wd1 <= mem_wdata_req;
      wd2 <= wd1;
      if (cache_read_data) wptr <= wptr + 16'd1;
   end

   // Strobe and data logger, sampled mid-cycle.
   always @(negedge clk) begin
      if (cache_write_data) begin
         fill_log[n_cwd % 1024] <= ddr_din;
         n_cwd <= n_cwd + 1;
      end
      if (vga_rdata_valid) begin
         vga_log[n_vrv % 1024] <= vga_rdata;
         n_vrv <= n_vrv + 1;
      end
      if (cache_read_data) n_crd <= n_crd + 1;
      if (vga_ack) n_ack <= n_ack + 1;
      if (32'(cache_write_data) + 32'(cache_read_data) +
          32'(vga_rdata_valid) > 1)
         n_multi <= n_multi + 1;
      if (wd2) begin
         n_wchk <= n_wchk + 1;
         if (mem_wdata !== 16'hA500 + n_wchk[15:0])
            n_wbad <= n_wbad + 1;
      end
   end

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_cmd(output bit got);
      got = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (mem_cmd_valid) begin
            got = 1'b1;
            break;
         end
         tick;
      end
   endtask

   task automatic burst(input logic we, input int dly,
                        input logic [15:0] base);
      for (int i = 0; i < dly; i++) tick;
      mem_cmd_ready = 1'b1;
      tick;
      mem_cmd_ready = 1'b0;
      for (int k = 0; k < 32; k++) begin
         if (we) begin
            mem_wdata_req = 1'b1;
         end else begin
            mem_rdata_valid = 1'b1;
            mem_rdata       = base + 16'(k);
         end
         tick;
      end
      mem_wdata_req   = 1'b0;
      mem_rdata_valid = 1'b0;
      for (int i = 0; i < 3; i++) tick;
   endtask

   typedef struct {
      logic        wr;
      logic        rd;
      logic        vga;
      logic [18:0] ha;
      logic [18:0] va;
      logic        ewe;
      logic        evga;
      logic [18:0] eaddr;
   } vec_t;

   vec_t vt [7];

   initial begin
      bit got;
      bit seen;
      int s_cwd, s_crd, s_vrv, s_ack, s_wchk, s_wbad;

      vt[0] = '{1'b0, 1'b1, 1'b0, 19'h00111, 19'h00222, 1'b0, 1'b0, 19'h00111};
      vt[1] = '{1'b1, 1'b0, 1'b0, 19'h00333, 19'h00444, 1'b1, 1'b0, 19'h00333};
      vt[2] = '{1'b0, 1'b0, 1'b1, 19'h00555, 19'h00666, 1'b0, 1'b1, 19'h00666};
      vt[3] = '{1'b1, 1'b1, 1'b0, 19'h00777, 19'h00888, 1'b1, 1'b0, 19'h00777};
      vt[4] = '{1'b0, 1'b1, 1'b1, 19'h00999, 19'h00AAA, 1'b0, 1'b0, 19'h00999};
      vt[5] = '{1'b1, 1'b0, 1'b1, 19'h00BBB, 19'h00CCC, 1'b1, 1'b0, 19'h00BBB};
      vt[6] = '{1'b1, 1'b1, 1'b1, 19'h7FFFF, 19'h00DDD, 1'b1, 1'b0, 19'h7FFFF};

      rst_n = 1'b0;
      ddr_rd = 1'b0; ddr_wr = 1'b0; vga_req = 1'b0;
      hiaddr = '0; vga_line_addr = '0;
      mem_cmd_ready = 1'b0; mem_rdata_valid = 1'b0;
      mem_rdata = '0; mem_wdata_req = 1'b0;

      #3;
      check("rst_outputs", 32'(|{cache_write_data, cache_read_data,
            ddr_din, vga_ack, vga_rdata_valid, vga_rdata, mem_cmd_valid,
            mem_cmd_we, mem_cmd_addr, mem_wdata}), 0);
      check("rst_busy", busy, 0);
      tick; tick;
      rst_n = 1'b1;
      tick;

      // Arbitration table, one burst per vector.
      for (int v = 0; v < 7; v++) begin
         s_cwd = n_cwd; s_crd = n_crd; s_vrv = n_vrv; s_ack = n_ack;
         hiaddr = vt[v].ha; vga_line_addr = vt[v].va;
         ddr_wr = vt[v].wr; ddr_rd = vt[v].rd; vga_req = vt[v].vga;
         wait_cmd(got);
         check($sformatf("v%0d_cmd", v), got, 1);
         check($sformatf("v%0d_we", v), mem_cmd_we, vt[v].ewe);
         check($sformatf("v%0d_addr", v), mem_cmd_addr, vt[v].eaddr);
         ddr_wr = 1'b0; ddr_rd = 1'b0; vga_req = 1'b0;
         burst(vt[v].ewe, 1, 16'h1000);
         check($sformatf("v%0d_ack", v), n_ack - s_ack, vt[v].evga);
         check($sformatf("v%0d_cwd", v), n_cwd - s_cwd,
               (!vt[v].ewe && !vt[v].evga) ? 32 : 0);
         check($sformatf("v%0d_crd", v), n_crd - s_crd, vt[v].ewe ? 32 : 0);
         check($sformatf("v%0d_vrv", v), n_vrv - s_vrv, vt[v].evga ? 32 : 0);
         check($sformatf("v%0d_busy", v), busy, 0);
      end

      // Line fill, slow command accept, address change after grant.
      s_cwd = n_cwd;
      hiaddr = 19'h01ABC; ddr_rd = 1'b1;
      wait_cmd(got);
      check("fill_cmd", got, 1);
      check("fill_we", mem_cmd_we, 0);
      check("fill_addr", mem_cmd_addr, 19'h01ABC);
      hiaddr = 19'h7FFFF;
      tick; tick; tick;
      check("fill_hold_valid", mem_cmd_valid, 1);
      check("fill_hold_addr", mem_cmd_addr, 19'h01ABC);
      burst(1'b0, 0, 16'h0000);
      check("fill_cnt", n_cwd - s_cwd, 32);
      for (int k = 0; k < 32; k++)
         check($sformatf("fill_word%0d", k), fill_log[(s_cwd + k) % 1024], k);
      check("fill_busy", busy, 0);

      // Held request is not serviced twice until it drops for a cycle.
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick;
         if (mem_cmd_valid) seen = 1'b1;
      end
      check("rearm_hold", seen, 0);
      ddr_rd = 1'b0;
      tick;
      ddr_rd = 1'b1;
      wait_cmd(got);
      check("rearm_cmd", got, 1);
      ddr_rd = 1'b0;
      burst(1'b0, 1, 16'h0010);

      // Write-back ahead of fill, both raised together.
      s_crd = n_crd; s_cwd = n_cwd; s_wchk = n_wchk; s_wbad = n_wbad;
      hiaddr = 19'h00155; ddr_wr = 1'b1; ddr_rd = 1'b1;
      wait_cmd(got);
      check("wb_cmd", got, 1);
      check("wb_we", mem_cmd_we, 1);
      ddr_wr = 1'b0;
      burst(1'b1, 1, 16'h0000);
      check("wb_crd", n_crd - s_crd, 32);
      check("wb_wdata_cnt", n_wchk - s_wchk, 32);
      check("wb_wdata_bad", n_wbad - s_wbad, 0);
      wait_cmd(got);
      check("wb_fill_cmd", got, 1);
      check("wb_fill_we", mem_cmd_we, 0);
      ddr_rd = 1'b0;
      burst(1'b0, 1, 16'h0100);
      check("wb_fill_cwd", n_cwd - s_cwd, 32);

      // Fill wins over VGA; VGA follows with its own strobes only.
      s_ack = n_ack;
      hiaddr = 19'h00123; vga_line_addr = 19'h00777;
      ddr_rd = 1'b1; vga_req = 1'b1;
      wait_cmd(got);
      check("vf_addr", mem_cmd_addr, 19'h00123);
      ddr_rd = 1'b0;
      burst(1'b0, 1, 16'h0000);
      s_cwd = n_cwd; s_vrv = n_vrv; s_crd = n_crd;
      wait_cmd(got);
      check("vf_vga_cmd", got, 1);
      check("vf_vga_addr", mem_cmd_addr, 19'h00777);
      check("vf_vga_ack", n_ack - s_ack, 1);
      vga_req = 1'b0;
      burst(1'b0, 1, 16'h0200);
      check("vf_vrv", n_vrv - s_vrv, 32);
      check("vf_no_cwd", n_cwd - s_cwd, 0);
      check("vf_no_crd", n_crd - s_crd, 0);
      check("vf_first", vga_log[s_vrv % 1024], 16'h0200);
      check("vf_last", vga_log[(s_vrv + 31) % 1024], 16'h021F);

      // Long-waiting VGA against write-back and a re-armed fill.
      hiaddr = 19'h00AAA; vga_line_addr = 19'h00BBB;
      ddr_rd = 1'b1; vga_req = 1'b1;
      wait_cmd(got);
      check("dl_first", mem_cmd_addr, 19'h00AAA);
      tick;
      ddr_rd = 1'b0;
      tick;
      ddr_rd = 1'b1; ddr_wr = 1'b1;
      burst(1'b0, 70, 16'h0300);
      wait_cmd(got);
      check("dl_wb_wins", mem_cmd_we, 1);
      ddr_wr = 1'b0;
      burst(1'b1, 1, 16'h0000);
      wait_cmd(got);
`ifdef VGA_DEADLINE_EN
      check("dl_second", mem_cmd_addr, 19'h00BBB);
`else
      check("dl_second", mem_cmd_addr, 19'h00AAA);
`endif
      burst(1'b0, 1, 16'h0400);
      wait_cmd(got);
`ifdef VGA_DEADLINE_EN
      check("dl_third", mem_cmd_addr, 19'h00AAA);
`else
      check("dl_third", mem_cmd_addr, 19'h00BBB);
`endif
      ddr_rd = 1'b0; vga_req = 1'b0;
      burst(1'b0, 1, 16'h0500);
      check("dl_busy", busy, 0);

      // Stray beats in IDLE leave strobes and word count alone.
      s_cwd = n_cwd; s_vrv = n_vrv;
      mem_rdata = 16'hDEAD;
      mem_rdata_valid = 1'b1;
      tick; tick; tick;
      mem_rdata_valid = 1'b0;
      tick; tick;
      check("stray_cwd", n_cwd - s_cwd, 0);
      check("stray_vrv", n_vrv - s_vrv, 0);
      ddr_rd = 1'b1;
      wait_cmd(got);
      ddr_rd = 1'b0;
      burst(1'b0, 1, 16'h0600);
      check("stray_fill_cnt", n_cwd - s_cwd, 32);
      check("stray_fill_last", ddr_din, 16'h061F);
      check("stray_busy", busy, 0);

      // Asynchronous reset at beat 12, then a clean burst.
      hiaddr = 19'h00042; ddr_rd = 1'b1;
      wait_cmd(got);
      mem_cmd_ready = 1'b1;
      tick;
      mem_cmd_ready = 1'b0;
      for (int k = 0; k < 12; k++) begin
         mem_rdata_valid = 1'b1;
         mem_rdata = 16'h0700 + 16'(k);
         tick;
      end
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_outputs", 32'(|{cache_write_data, cache_read_data,
            ddr_din, vga_ack, vga_rdata_valid, vga_rdata, mem_cmd_valid,
            mem_cmd_we, mem_cmd_addr, mem_wdata}), 0);
      check("midrst_busy", busy, 0);
      mem_rdata_valid = 1'b0;
      ddr_rd = 1'b0;
      tick; tick;
      rst_n = 1'b1;
      tick;
      s_cwd = n_cwd;
      ddr_rd = 1'b1;
      wait_cmd(got);
      check("postrst_cmd", got, 1);
      ddr_rd = 1'b0;
      burst(1'b0, 1, 16'h0800);
      check("postrst_cnt", n_cwd - s_cwd, 32);
      check("postrst_first", fill_log[s_cwd % 1024], 16'h0800);
      check("postrst_busy", busy, 0);

      check("no_double_strobe", n_multi, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
